// File: rtl/zap_mem_request_unit.sv
// Memory request unit: turns one pipeline memory op into a single cache bus cycle,
// with alignment faulting, ack timeout and flush-safe draining of outstanding cycles.
module zap_mem_request_unit #(
    parameter int ALIGN_CHECK    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear_from_writeback,
    input  logic        i_req_valid,
    input  logic        i_req_load,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic        i_byte,
    input  logic        i_half,
    output logic        o_cache_stb,
    output logic        o_cache_wen,
    output logic [31:0] o_cache_addr,
    output logic [31:0] o_cache_wdata,
    output logic [3:0]  o_cache_ben,
    input  logic        i_cache_ack,
    input  logic [31:0] i_cache_rdata,
    input  logic [1:0]  i_cache_fault,
    output logic        o_data_stall,
    output logic        o_mem_done,
    output logic [31:0] o_mem_rd_data,
    output logic [1:0]  o_mem_fault
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int            CW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST   = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [3:0]    ben_q, ben_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [1:0]    fault_q, fault_d;

    logic          is_word;
    logic          misaligned;
    logic          accept;
    logic          timed_out;
    logic [3:0]    req_ben;
    logic [31:0]   req_wdata;

    // Lane enables and replicated store data, so the cache can pick any lane.
    always_comb begin
        is_word    = !i_byte && !i_half;
        misaligned = (ALIGN_CHECK != 0) &&
                     ((i_half && !i_byte && i_req_addr[0]) ||
                      (is_word && (i_req_addr[1:0] != 2'b00)));
        accept     = (state_q == IDLE) && i_req_valid && !i_clear_from_writeback;
        timed_out  = TIMEOUT_EN && (cnt_q == CNT_LAST);
        req_ben    = 4'b1111;
        req_wdata  = i_req_wdata;
        if (i_byte) begin
            req_wdata = {4{i_req_wdata[7:0]}};
            if (!i_req_load) req_ben = 4'b0001 << i_req_addr[1:0];
        end else if (i_half) begin
            req_wdata = {2{i_req_wdata[15:0]}};
            if (!i_req_load) req_ben = i_req_addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        ben_d     = ben_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        rd_data_d = rd_data_q;
        fault_d   = fault_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (misaligned) begin
                        done_d  = 1'b1;
                        fault_d = 2'b01;
                    end else begin
                        state_d = WAIT;
                        addr_d  = i_req_addr;
                        wen_d   = !i_req_load;
                        ben_d   = req_ben;
                        wdata_d = req_wdata;
                    end
                end
            end
            // A flush never abandons a bus cycle; it only suppresses the result.
            WAIT: begin
                if (i_cache_ack) begin
                    state_d = IDLE;
                    if (!i_clear_from_writeback) begin
                        done_d  = 1'b1;
                        fault_d = i_cache_fault;
                        if (!wen_q) rd_data_d = i_cache_rdata;
                    end
                end else if (timed_out) begin
                    state_d = IDLE;
                    if (!i_clear_from_writeback) begin
                        done_d  = 1'b1;
                        fault_d = 2'b11;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (i_clear_from_writeback) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (i_cache_ack || timed_out) state_d = IDLE;
                else                          cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            ben_q     <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            fault_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            ben_q     <= ben_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            fault_q   <= fault_d;
        end
    end

    // Strobe follows state so that reset drops it asynchronously.
    assign o_cache_stb   = (state_q != IDLE);
    assign o_data_stall  = (state_q != IDLE);
    assign o_cache_wen   = o_cache_stb && wen_q;
    assign o_cache_addr  = addr_q;
    assign o_cache_wdata = wdata_q;
    assign o_cache_ben   = ben_q;
    assign o_mem_done    = done_q;
    assign o_mem_rd_data = rd_data_q;
    assign o_mem_fault   = fault_q;

endmodule

// File: tb/tb_zap_mem_request_unit.sv
// Scoreboard bench for zap_mem_request_unit: a main instance (align checking, timeout 8)
// and a second instance (no align check, timeout 4) with its own valid/ack.
module tb_zap_mem_request_unit;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear, valid, load, req_byte, req_half;
    logic [31:0] addr, wdata;
    logic        ack, valid2, ack2;
    logic [31:0] rdata;
    logic [1:0]  cfault;

    logic        m_stb, m_wen, m_stall, m_done;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [3:0]  m_ben;
    logic [1:0]  m_fault;

    logic        s_stb, s_wen, s_stall, s_done;
    logic [31:0] s_addr, s_wdata, s_rd;
    logic [3:0]  s_ben;
    logic [1:0]  s_fault;

    exp_t        sb[$];
    exp_t        sb2[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rd;
    logic [1:0]  model_fault;

    always #5 clk = ~clk;

    zap_mem_request_unit #(.ALIGN_CHECK(1), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_clear_from_writeback(clear),
        .i_req_valid(valid), .i_req_load(load), .i_req_addr(addr), .i_req_wdata(wdata),
        .i_byte(req_byte), .i_half(req_half),
        .o_cache_stb(m_stb), .o_cache_wen(m_wen), .o_cache_addr(m_addr),
        .o_cache_wdata(m_wdata), .o_cache_ben(m_ben),
        .i_cache_ack(ack), .i_cache_rdata(rdata), .i_cache_fault(cfault),
        .o_data_stall(m_stall), .o_mem_done(m_done), .o_mem_rd_data(m_rd), .o_mem_fault(m_fault)
    );

    zap_mem_request_unit #(.ALIGN_CHECK(0), .TIMEOUT_CYCLES(4)) dut2 (
        .i_clk(clk), .i_reset_n(reset_n), .i_clear_from_writeback(clear),
        .i_req_valid(valid2), .i_req_load(load), .i_req_addr(addr), .i_req_wdata(wdata),
        .i_byte(req_byte), .i_half(req_half),
        .o_cache_stb(s_stb), .o_cache_wen(s_wen), .o_cache_addr(s_addr),
        .o_cache_wdata(s_wdata), .o_cache_ben(s_ben),
        .i_cache_ack(ack2), .i_cache_rdata(rdata), .i_cache_fault(cfault),
        .o_data_stall(s_stall), .o_mem_done(s_done), .o_mem_rd_data(s_rd), .o_mem_fault(s_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic ld, input logic [31:0] a, input logic [31:0] d,
                             input logic b, input logic h);
        valid    = 1'b1;
        load     = ld;
        addr     = a;
        wdata    = d;
        req_byte = b;
        req_half = h;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear = 0; valid = 0; load = 0; req_byte = 0; req_half = 0;
        addr = 0; wdata = 0; ack = 0; valid2 = 0; ack2 = 0; rdata = 0; cfault = 0;
        model_rd = 32'h0;
        model_fault = 2'b00;
        #12;
        checks++; if (m_stb !== 1'b0) begin errors++; $display("[TB] FAIL reset_stb: got %b want 0", m_stb); end
        checks++; if (m_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", m_stall); end
        checks++; if (m_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", m_done); end
        checks++; if (m_ben !== 4'h0) begin errors++; $display("[TB] FAIL reset_ben: got %h want 0", m_ben); end
        checks++; if (m_rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd: got %h want 0", m_rd); end
        checks++; if (m_fault !== 2'b00) begin errors++; $display("[TB] FAIL reset_fault: got %b want 00", m_fault); end
        checks++; if (s_stb !== 1'b0) begin errors++; $display("[TB] FAIL reset_stb2: got %b want 0", s_stb); end
        #1 reset_n = 1'b1;
        step();
    endtask

    task automatic test_load_ack();
        exp_t e;
        e.rd = 32'hA1B2C3D4; e.fault = 2'b00;
        sb.push_back(e);
        drive_req(1'b1, 32'h100, 32'h0, 1'b0, 1'b0);
        step();
        valid = 0;
        checks++; if (m_stb !== 1'b1) begin errors++; $display("[TB] FAIL load_stb: got %b want 1", m_stb); end
        checks++; if (m_stall !== 1'b1) begin errors++; $display("[TB] FAIL load_stall: got %b want 1", m_stall); end
        checks++; if (m_addr !== 32'h100) begin errors++; $display("[TB] FAIL load_addr: got %h want 100", m_addr); end
        checks++; if (m_ben !== 4'hF || m_wen !== 1'b0) begin errors++; $display("[TB] FAIL load_ben_wen: got %h/%b want f/0", m_ben, m_wen); end
        ack = 1; rdata = 32'hA1B2C3D4; cfault = 2'b00;
        step();
        ack = 0;
        checks++; if (m_stb !== 1'b0 || m_stall !== 1'b0) begin errors++; $display("[TB] FAIL load_stb_drop: got %b/%b want 0/0", m_stb, m_stall); end
        checks++; if (m_done !== 1'b1) begin errors++; $display("[TB] FAIL load_done: got %b want 1", m_done); end
        e = sb.pop_front();
        checks++; if (m_rd !== e.rd) begin errors++; $display("[TB] FAIL load_rd: got %h want %h", m_rd, e.rd); end
        checks++; if (m_fault !== e.fault) begin errors++; $display("[TB] FAIL load_fault: got %b want %b", m_fault, e.fault); end
        model_rd = e.rd; model_fault = e.fault;
        step();
        checks++; if (m_done !== 1'b0) begin errors++; $display("[TB] FAIL load_done_pulse: got %b want 0", m_done); end
    endtask

    task automatic test_store();
        exp_t e;
        e.rd = model_rd; e.fault = 2'b00;
        sb.push_back(e);
        drive_req(1'b0, 32'h203, 32'h0000005A, 1'b1, 1'b0);
        step();
        valid = 0;
        checks++; if (m_ben !== 4'b1000) begin errors++; $display("[TB] FAIL sb_ben: got %b want 1000", m_ben); end
        checks++; if (m_wdata !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL sb_wdata: got %h want 5a5a5a5a", m_wdata); end
        checks++; if (m_wen !== 1'b1) begin errors++; $display("[TB] FAIL sb_wen: got %b want 1", m_wen); end
        ack = 1; rdata = 32'hFFFFFFFF; cfault = 2'b00;
        step();
        ack = 0;
        e = sb.pop_front();
        checks++; if (m_done !== 1'b1 || m_rd !== e.rd || m_fault !== e.fault)
            begin errors++; $display("[TB] FAIL sb_done: got %b/%h/%b want 1/%h/%b", m_done, m_rd, m_fault, e.rd, e.fault); end
        model_fault = e.fault;

        e.rd = model_rd; e.fault = 2'b10;
        sb.push_back(e);
        drive_req(1'b0, 32'h202, 32'hABCD1234, 1'b0, 1'b1);
        step();
        valid = 0;
        checks++; if (m_ben !== 4'b1100) begin errors++; $display("[TB] FAIL sh_ben: got %b want 1100", m_ben); end
        checks++; if (m_wdata !== 32'h12341234) begin errors++; $display("[TB] FAIL sh_wdata: got %h want 12341234", m_wdata); end
        ack = 1; rdata = 32'h0; cfault = 2'b10;
        step();
        ack = 0; cfault = 2'b00;
        e = sb.pop_front();
        checks++; if (m_done !== 1'b1 || m_rd !== e.rd || m_fault !== e.fault)
            begin errors++; $display("[TB] FAIL sh_done: got %b/%h/%b want 1/%h/%b", m_done, m_rd, m_fault, e.rd, e.fault); end
        model_fault = e.fault;
        step();
    endtask

    // Each access takes exactly two edges: accept, then ack edge; the next accept coincides with done.
    task automatic test_back_to_back();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.rd = 32'h10000000 + 32'(k); e.fault = 2'b00;
            sb.push_back(e);
            drive_req(1'b1, 32'h300 + 32'(4 * k), 32'h0, 1'b0, 1'b0);
            step();
            valid = 0;
            checks++; if (m_stb !== 1'b1 || m_addr !== 32'h300 + 32'(4 * k))
                begin errors++; $display("[TB] FAIL b2b_stb_%0d: got %b/%h want 1/%h", k, m_stb, m_addr, 32'h300 + 32'(4 * k)); end
            ack = 1; rdata = e.rd;
            step();
            ack = 0;
            e = sb.pop_front();
            checks++; if (m_done !== 1'b1 || m_stb !== 1'b0 || m_rd !== e.rd)
                begin errors++; $display("[TB] FAIL b2b_done_%0d: got %b/%b/%h want 1/0/%h", k, m_done, m_stb, m_rd, e.rd); end
            model_rd = e.rd; model_fault = e.fault;
        end
        step();
    endtask

    task automatic test_idle_ack();
        ack = 1; rdata = 32'h77777777;
        step();
        step();
        ack = 0;
        checks++; if (m_done !== 1'b0 || m_stb !== 1'b0 || m_rd !== model_rd)
            begin errors++; $display("[TB] FAIL idle_ack: got %b/%b/%h want 0/0/%h", m_done, m_stb, m_rd, model_rd); end
    endtask

    task automatic test_misaligned();
        exp_t e;
        e.rd = model_rd; e.fault = 2'b01;
        sb.push_back(e);
        drive_req(1'b1, 32'h101, 32'h0, 1'b0, 1'b0);
        step();
        valid = 0;
        e = sb.pop_front();
        checks++; if (m_stb !== 1'b0 || m_stall !== 1'b0) begin errors++; $display("[TB] FAIL mis_nostb: got %b/%b want 0/0", m_stb, m_stall); end
        checks++; if (m_done !== 1'b1 || m_fault !== e.fault || m_rd !== e.rd)
            begin errors++; $display("[TB] FAIL mis_done: got %b/%b/%h want 1/%b/%h", m_done, m_fault, m_rd, e.fault, e.rd); end
        model_fault = e.fault;
        step();
        drive_req(1'b1, 32'h101, 32'h0, 1'b0, 1'b0);
        clear = 1;
        step();
        valid = 0; clear = 0;
        checks++; if (m_done !== 1'b0 || m_stb !== 1'b0) begin errors++; $display("[TB] FAIL mis_clear: got %b/%b want 0/0", m_done, m_stb); end
    endtask

    task automatic test_no_align();
        exp_t e;
        e.rd = 32'h0BADF00D; e.fault = 2'b00;
        sb2.push_back(e);
        drive_req(1'b1, 32'h101, 32'h0, 1'b0, 1'b0);
        valid = 0; valid2 = 1;
        step();
        valid2 = 0;
        checks++; if (s_stb !== 1'b1 || s_addr !== 32'h101) begin errors++; $display("[TB] FAIL noalign_stb: got %b/%h want 1/101", s_stb, s_addr); end
        ack2 = 1; rdata = 32'h0BADF00D;
        step();
        ack2 = 0;
        e = sb2.pop_front();
        checks++; if (s_done !== 1'b1 || s_rd !== e.rd || s_fault !== e.fault)
            begin errors++; $display("[TB] FAIL noalign_done: got %b/%h/%b want 1/%h/%b", s_done, s_rd, s_fault, e.rd, e.fault); end
        step();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n;
        e.rd = 32'h0BADF00D; e.fault = 2'b11;
        sb2.push_back(e);
        drive_req(1'b0, 32'h40, 32'h11, 1'b0, 1'b0);
        valid = 0; valid2 = 1;
        step();
        valid2 = 0;
        n = 0;
        while (s_stb === 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++; if (n != 4) begin errors++; $display("[TB] FAIL timeout_len: got %0d want 4", n); end
        e = sb2.pop_front();
        checks++; if (s_done !== 1'b1 || s_fault !== e.fault || s_stall !== 1'b0 || s_rd !== e.rd)
            begin errors++; $display("[TB] FAIL timeout_done: got %b/%b/%b/%h want 1/%b/0/%h", s_done, s_fault, s_stall, s_rd, e.fault, e.rd); end
        step();
    endtask

    task automatic test_clear_drain();
        drive_req(1'b1, 32'h400, 32'h0, 1'b0, 1'b0);
        step();
        valid = 0;
        step();
        clear = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            clear = 0;
            checks++; if (m_stb !== 1'b1 || m_stall !== 1'b1 || m_done !== 1'b0 || m_addr !== 32'h400)
                begin errors++; $display("[TB] FAIL drain_hold_%0d: got %b/%b/%b/%h want 1/1/0/400", i, m_stb, m_stall, m_done, m_addr); end
        end
        ack = 1; rdata = 32'hBAD0BAD0; cfault = 2'b10;
        step();
        ack = 0; cfault = 2'b00;
        checks++; if (m_stb !== 1'b0 || m_stall !== 1'b0 || m_done !== 1'b0)
            begin errors++; $display("[TB] FAIL drain_end: got %b/%b/%b want 0/0/0", m_stb, m_stall, m_done); end
        checks++; if (m_rd !== model_rd || m_fault !== model_fault)
            begin errors++; $display("[TB] FAIL drain_result: got %h/%b want %h/%b", m_rd, m_fault, model_rd, model_fault); end
        step();
    endtask

    task automatic test_clear_ack();
        drive_req(1'b1, 32'h500, 32'h0, 1'b0, 1'b0);
        step();
        valid = 0;
        clear = 1; ack = 1; rdata = 32'h12345678; cfault = 2'b10;
        step();
        clear = 0; ack = 0; cfault = 2'b00;
        checks++; if (m_stb !== 1'b0 || m_done !== 1'b0 || m_rd !== model_rd || m_fault !== model_fault)
            begin errors++; $display("[TB] FAIL clear_ack: got %b/%b/%h/%b want 0/0/%h/%b", m_stb, m_done, m_rd, m_fault, model_rd, model_fault); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        bit   got;
        drive_req(1'b1, 32'h600, 32'h0, 1'b0, 1'b0);
        step();
        valid = 0;
        checks++; if (m_stb !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_stb: got %b want 1", m_stb); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (m_stb !== 1'b0 || m_stall !== 1'b0 || m_done !== 1'b0)
            begin errors++; $display("[TB] FAIL rst_async: got %b/%b/%b want 0/0/0", m_stb, m_stall, m_done); end
        checks++; if (m_rd !== 32'h0 || m_fault !== 2'b00) begin errors++; $display("[TB] FAIL rst_result: got %h/%b want 0/00", m_rd, m_fault); end
        model_rd = 32'h0; model_fault = 2'b00;
        #3 reset_n = 1'b1;
        e.rd = 32'hCAFEF00D; e.fault = 2'b00;
        sb.push_back(e);
        drive_req(1'b1, 32'h700, 32'h0, 1'b0, 1'b0);
        step();
        valid = 0;
        checks++; if (m_stb !== 1'b1 || m_addr !== 32'h700) begin errors++; $display("[TB] FAIL rst_first_accept: got %b/%h want 1/700", m_stb, m_addr); end
        ack = 1; rdata = 32'hCAFEF00D;
        step();
        ack = 0;
        got = m_done;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            got = m_done;
        end
        e = sb.pop_front();
        checks++; if (!got || m_rd !== e.rd) begin errors++; $display("[TB] FAIL rst_load: got done=%b rd=%h want 1/%h", got, m_rd, e.rd); end
        step();
    endtask

    initial begin
        test_reset();
        test_load_ack();
        test_store();
        test_back_to_back();
        test_idle_ack();
        test_misaligned();
        test_no_align();
        test_timeout();
        test_clear_drain();
        test_clear_ack();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/zap_mem_request_unit.md
ZAP_MEM_REQUEST_UNIT -- requirements
Module: zap_mem_request_unit

Interface
REQ-001 SHALL have parameter ALIGN_CHECK, default 1: 1 = misaligned halfword/word access faults without a bus cycle.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of strobe cycles with no ack before a timeout fault; 0 disables the timeout.
REQ-003 SHALL have one clock and an asynchronous active-low reset: i_clk in 1 (all state on rising edge), i_reset_n in 1.
REQ-004 SHALL have these pipeline-side inputs: i_clear_from_writeback in 1 flush; i_req_valid in 1 memory op present; i_req_load in 1 (1 load, 0 store); i_req_addr in 32; i_req_wdata in 32 store data (value in low bits); i_byte in 1; i_half in 1 (neither set = word).
REQ-005 SHALL have these cache-side ports: o_cache_stb out 1; o_cache_wen out 1; o_cache_addr out 32; o_cache_wdata out 32; o_cache_ben out 4; i_cache_ack in 1; i_cache_rdata in 32; i_cache_fault in 2, valid with ack.
REQ-006 SHALL have these result ports toward the memory stage: o_data_stall out 1; o_mem_done out 1, one-cycle pulse; o_mem_rd_data out 32, raw unrotated word; o_mem_fault out 2 (00 none, 01 align, 10/11 cache code, 11 also timeout).

Function
REQ-007 SHALL implement a state machine with states IDLE, WAIT and DRAIN.
REQ-008 SHALL make o_data_stall a function of state only: 1 in WAIT and DRAIN, 0 in IDLE.
REQ-009 In IDLE with i_req_valid=1 and i_clear_from_writeback=0, SHALL accept the request and register the address, wen, ben and wdata.
REQ-010 After an accepted aligned request, SHALL go to WAIT with o_cache_stb=1 from the next cycle.
REQ-011 While in WAIT, SHALL hold o_cache_stb, addr, wen, ben and wdata stable until ack.
REQ-012 SHALL set o_cache_ben and o_cache_wdata as follows: byte -> ben = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}; half -> ben = addr[1]?1100:0011, wdata = {2{wdata[15:0]}}; word -> ben = 1111, wdata unchanged.
REQ-013 For loads, SHALL drive ben = 1111 and wen = 0; o_cache_addr SHALL equal i_req_addr unmodified.
REQ-014 With ALIGN_CHECK=1, SHALL treat half with addr[0]=1, or word with addr[1:0]!=0, as misaligned.
REQ-015 For a misaligned request, SHALL issue no strobe, stay in IDLE, and pulse o_mem_done with o_mem_fault=01 on the next cycle.
REQ-016 On ack in WAIT, SHALL on the next cycle drop stb, pulse o_mem_done, register o_mem_rd_data=i_cache_rdata (loads only; stores leave it unchanged) and o_mem_fault=i_cache_fault, and go to IDLE.
REQ-017 SHALL achieve single-cycle-ack throughput of one access per 2 cycles: accept c0, stb c1, ack c1, done+IDLE c2, next accept c2.
REQ-018 SHALL keep a wait counter that clears on accept and increments each WAIT cycle without ack.
REQ-019 If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without ack, SHALL drop stb, pulse done with fault 11 and go to IDLE.
REQ-020 On clear in WAIT, SHALL go to DRAIN and keep stb asserted, because bus cycles are never abandoned.
REQ-021 In DRAIN, SHALL on ack or timeout go to IDLE with no done pulse and rd_data/fault unchanged.
REQ-022 On clear in IDLE, SHALL ignore i_req_valid that cycle and suppress a pending misaligned done pulse.
REQ-023 When clear and ack occur in the same WAIT cycle, SHALL discard the result and go to IDLE.
REQ-024 SHALL ignore i_cache_ack while in IDLE.

Reset
REQ-025 Asserting i_reset_n=0 SHALL immediately set state IDLE, counter 0, and all outputs 0, including o_cache_ben, o_mem_rd_data and o_mem_fault.
REQ-026 Reset mid-WAIT SHALL drop stb asynchronously with no done pulse.
REQ-027 After deassertion, the first accept SHALL be possible on the first rising edge.

Verification
REQ-028 Load addr 0x100, ack in 1st stb cycle with rdata 0xA1B2C3D4 -> stb for 1 cycle, done next cycle, rd_data=0xA1B2C3D4, fault 00, stall high 1 cycle.
REQ-029 Store byte 0x5A at addr 0x203 -> ben 1000, wdata 0x5A5A5A5A, wen 1; store half 0x1234 at 0x202 -> ben 1100, wdata 0x12341234.
REQ-030 Word load at 0x101, ALIGN_CHECK=1 -> no stb, done next cycle, fault 01; with ALIGN_CHECK=0 -> bus cycle issued at 0x101.
REQ-031 TIMEOUT_CYCLES=4 and no ack -> stb exactly 4 cycles, then done with fault 11 and state IDLE.
REQ-032 Clear in 2nd WAIT cycle, ack 3 cycles later -> stb held until ack, stall high throughout, no done, rd_data unchanged.
REQ-033 i_reset_n low mid-WAIT -> stb, stall and done 0 asynchronously; after release, a load accepts on the first edge.
